// File: rtl/fpu_pkg.sv
// Shared FPU definitions: compare/min-max op encodings, class-vector bit
// indices and the canonical single-precision NaN.
package fpu_pkg;

  localparam logic [2:0] FCMP_FEQ  = 3'd0;
  localparam logic [2:0] FCMP_FLT  = 3'd1;
  localparam logic [2:0] FCMP_FLE  = 3'd2;
  localparam logic [2:0] FCMP_FMIN = 3'd3;
  localparam logic [2:0] FCMP_FMAX = 3'd4;

  localparam int CLS_NEG_INF  = 0;
  localparam int CLS_NEG_NORM = 1;
  localparam int CLS_NEG_SUB  = 2;
  localparam int CLS_NEG_ZERO = 3;
  localparam int CLS_POS_ZERO = 4;
  localparam int CLS_POS_SUB  = 5;
  localparam int CLS_POS_NORM = 6;
  localparam int CLS_POS_INF  = 7;
  localparam int CLS_SNAN     = 8;
  localparam int CLS_QNAN     = 9;

  localparam logic [31:0] CANON_NAN_S = 32'h7FC00000;

endpackage

// File: rtl/fp_mag_cmp.sv
// Combinational sign-magnitude ordering of two FP operands; zero_equal_i
// selects whether -0 and +0 tie (compares) or order as -0 < +0 (min/max).
module fp_mag_cmp #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         zero_equal_i,
  output logic         lt_o,
  output logic         eq_o
);

  logic         sa, sb;
  logic [W-2:0] ma, mb;

  assign sa = a_i[W-1];
  assign sb = b_i[W-1];
  assign ma = a_i[W-2:0];
  assign mb = b_i[W-2:0];

  always_comb begin
    lt_o = 1'b0;
    eq_o = (a_i == b_i);
    if (zero_equal_i && (ma == '0) && (mb == '0)) begin
      eq_o = 1'b1;
    end else if (sa != sb) begin
      lt_o = sa;
    end else if (sa) begin
      // both negative: larger magnitude is the smaller value
      lt_o = (ma > mb);
    end else begin
      lt_o = (ma < mb);
    end
  end

endmodule

// File: rtl/fcmp_minmax.sv
// Two-stage FP compare / min-max unit with valid/ready on both sides.
// Optional sticky NV accumulator enabled by `define FCMP_STICKY_FLAGS_EN.
module fcmp_minmax
  import fpu_pkg::*;
#(
  parameter int EXPWIDTH = 8,
  parameter int SIGWIDTH = 24,
  parameter int XLEN     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   op,
  input  logic [EXPWIDTH+SIGWIDTH-1:0] frs1,
  input  logic [EXPWIDTH+SIGWIDTH-1:0] frs2,
  input  logic [XLEN-1:0]              cls1,
  input  logic [XLEN-1:0]              cls2,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              result,
  output logic                         nv,
  input  logic                         nv_clr,
  output logic                         sticky_nv
);

  localparam int OPW = EXPWIDTH + SIGWIDTH;

  logic            adv1, adv2;
  logic            s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [2:0]      op_q;
  logic [OPW-1:0]  a_q, b_q;
  logic            qnan1_q, snan1_q, qnan2_q, snan2_q;
  logic [XLEN-1:0] result_q, result_d;
  logic            nv_q, nv_d;
  logic            zero_eq, lt_c, eq_c;
  logic [OPW-1:0]  res_c;
  logic            nv_c;

  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  assign s1_valid_d = adv1 ? in_valid : s1_valid_q;
  assign s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;

  // Stage 1: capture operands and only the NaN bits of the class vectors
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      op_q    <= op;
      a_q     <= frs1;
      b_q     <= frs2;
      qnan1_q <= cls1[CLS_QNAN];
      snan1_q <= cls1[CLS_SNAN];
      qnan2_q <= cls2[CLS_QNAN];
      snan2_q <= cls2[CLS_SNAN];
    end
  end

  assign zero_eq = (op_q == FCMP_FEQ) || (op_q == FCMP_FLT) || (op_q == FCMP_FLE);

  fp_mag_cmp #(.W(OPW)) u_mag_cmp (
    .a_i          (a_q),
    .b_i          (b_q),
    .zero_equal_i (zero_eq),
    .lt_o         (lt_c),
    .eq_o         (eq_c)
  );

  always_comb begin
    logic nan1, nan2, any_nan, any_snan;
    nan1     = qnan1_q | snan1_q;
    nan2     = qnan2_q | snan2_q;
    any_nan  = nan1 | nan2;
    any_snan = snan1_q | snan2_q;
    res_c    = '0;
    nv_c     = 1'b0;
    case (op_q)
      FCMP_FEQ: begin
        res_c = OPW'(!any_nan && eq_c);
        nv_c  = any_snan;
      end
      FCMP_FLT: begin
        res_c = OPW'(!any_nan && lt_c);
        nv_c  = any_nan;
      end
      FCMP_FLE: begin
        res_c = OPW'(!any_nan && (lt_c || eq_c));
        nv_c  = any_nan;
      end
      FCMP_FMIN, FCMP_FMAX: begin
        nv_c = any_snan;
        if (nan1 && nan2)  res_c = OPW'(CANON_NAN_S);
        else if (nan1)     res_c = b_q;
        else if (nan2)     res_c = a_q;
        else if ((op_q == FCMP_FMIN) == lt_c) res_c = a_q;
        else               res_c = b_q;
      end
      default: begin
        res_c = '0;
        nv_c  = 1'b0;
      end
    endcase
  end

  assign result_d = (adv2 && s1_valid_q) ? XLEN'(res_c) : result_q;
  assign nv_d     = (adv2 && s1_valid_q) ? nv_c : nv_q;

  // Stage 2: result register drives the outputs directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      nv_q       <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      nv_q       <= nv_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign nv        = nv_q;

`ifdef FCMP_STICKY_FLAGS_EN
  logic sticky_q, sticky_d;

  // a new NV transfer wins over a simultaneous clear
  always_comb begin
    sticky_d = sticky_q;
    if (nv_clr)                           sticky_d = 1'b0;
    if (s2_valid_q && out_ready && nv_q)  sticky_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign sticky_nv = sticky_q;

  logic unused_in;
  assign unused_in = ^{cls1[XLEN-1:10], cls1[7:0], cls2[XLEN-1:10], cls2[7:0]};
`else
  assign sticky_nv = 1'b0;

  logic unused_in;
  assign unused_in = ^{cls1[XLEN-1:10], cls1[7:0], cls2[XLEN-1:10], cls2[7:0], nv_clr};
`endif

endmodule
